// File: rtl/oh_aoi_pipe.sv
// Pipelined And-Or-Invert array with a valid/ready register chain of STAGES slots.
// Build option OH_AOI_PIPE_HOLD_EN: empty stages keep their last data instead of tracking the input.
module oh_aoi_pipe #(
  parameter int DW     = 1,
  parameter int N      = 3,
  parameter int M      = 1,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            inv,
  input  logic [N*DW-1:0] a,
  input  logic [M*DW-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   z,
  output logic            busy
);

  function automatic logic [DW-1:0] aoi_calc(input logic [N*DW-1:0] av,
                                             input logic [M*DW-1:0] bv,
                                             input logic            iv);
    logic [DW-1:0] p;
    logic [DW-1:0] s;
    p = '1;
    s = '0;
    for (int i = 0; i < N; i++) p = p & av[i*DW +: DW];
    for (int j = 0; j < M; j++) s = s | bv[j*DW +: DW];
    s = s | p;
    return iv ? ~s : s;
  endfunction

  logic signed [DW-1:0] res_p0;
  logic                 vld_p [STAGES];
  logic signed [DW-1:0] dat_p [STAGES];
  logic                 rdy   [STAGES];
  logic                 rdy_acc;
  logic                 busy_acc;

  assign res_p0 = aoi_calc(a, b, inv);

  // A stage is ready when it, or any stage after it, is empty, or the consumer takes the head.
  always_comb begin
    rdy_acc  = out_ready;
    busy_acc = 1'b0;
    for (int r = STAGES - 1; r >= 0; r--) begin
      rdy_acc  = rdy_acc | ~vld_p[r];
      busy_acc = busy_acc | vld_p[r];
      rdy[r]   = rdy_acc;
    end
  end

  genvar r;
  for (r = 0; r < STAGES; r++) begin : g_stage
    logic                 src_vld;
    logic signed [DW-1:0] src_dat;

    if (r == 0) begin : g_head
      assign src_vld = in_valid;
      assign src_dat = res_p0;
    end else begin : g_body
      assign src_vld = vld_p[r-1];
      assign src_dat = dat_p[r-1];
    end

    // Stage boundary r: valid and data advance together under rdy[r].
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        vld_p[r] <= 1'b0;
        dat_p[r] <= '0;
      end else if (rdy[r]) begin
        vld_p[r] <= src_vld;
`ifdef OH_AOI_PIPE_HOLD_EN
        if (src_vld) dat_p[r] <= src_dat;
`else
        dat_p[r] <= src_dat;
`endif
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_p[STAGES-1];
  assign z         = dat_p[STAGES-1];
  assign busy      = busy_acc;

endmodule

// File: tb/tb_oh_aoi_pipe.sv
// Bench for oh_aoi_pipe: beat/position scoreboard checked every cycle plus directed literal checks.
module tb_oh_aoi_pipe;
  localparam int DW = 4;
  localparam int N = 3;
  localparam int M = 1;
  localparam int STAGES = 2;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            inv = 1'b0;
  logic [N*DW-1:0] a = '0;
  logic [M*DW-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   z;
  logic            busy;

  int cmp_cnt = 0;
  int err_cnt = 0;

  oh_aoi_pipe #(.DW(DW), .N(N), .M(M), .STAGES(STAGES)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .inv(inv), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain per-bit reading of the AND-OR-INVERT rule.
  function automatic logic [DW-1:0] model(input logic [N*DW-1:0] av, input logic [M*DW-1:0] bv,
                                         input logic iv);
    logic [DW-1:0] r;
    for (int k = 0; k < DW; k++) begin
      bit all_a = 1;
      bit any_b = 0;
      for (int i = 0; i < N; i++) if (av[i*DW+k] == 1'b0) all_a = 0;
      for (int j = 0; j < M; j++) if (bv[j*DW+k] == 1'b1) any_b = 1;
      r[k] = (all_a || any_b) ? !iv : iv;
    end
    return r;
  endfunction

  // Scoreboard: each in-flight beat has a slot position; beats compress toward the output.
  int            pos_q[$];
  logic [DW-1:0] val_q[$];
  logic [DW-1:0] last_val = '0;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pos_q.delete();
      val_q.delete();
      last_val = '0;
    end else begin
      bit acc;
      int lim;
      int np;
      acc = in_valid && ((pos_q.size() < STAGES) || out_ready);
      if (pos_q.size() > 0 && pos_q[0] == STAGES - 1 && out_ready) begin
        last_val = val_q[0];
        void'(pos_q.pop_front());
        void'(val_q.pop_front());
      end
      for (int i = 0; i < pos_q.size(); i++) begin
        if (i == 0) lim = STAGES - 1;
        else lim = pos_q[i-1] - 1;
        np = pos_q[i] + 1;
        if (np > lim) np = lim;
        pos_q[i] = np;
      end
      if (acc) begin
        pos_q.push_back(0);
        val_q.push_back(model(a, b, inv));
      end
    end
  end

  always @(negedge clk) begin
    if (!nreset) begin
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      chk("rst_z", {28'b0, z}, 0);
    end else begin
      bit exp_ov;
      exp_ov = (pos_q.size() > 0) && (pos_q[0] == STAGES - 1);
      chk("sb_out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      chk("sb_busy", {31'b0, busy}, {31'b0, pos_q.size() > 0});
      chk("sb_in_ready", {31'b0, in_ready},
          {31'b0, (pos_q.size() < STAGES) || out_ready});
      if (exp_ov) chk("sb_z", {28'b0, z}, {28'b0, val_q[0]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 50 && busy; i++) cyc();
    chk("drain_busy", {31'b0, busy}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] held;
    int sent;
    // Reset state, outputs checked while nreset is low.
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 1);
    chk("reset_out_valid", {31'b0, out_valid}, 0);
    cyc();
    cyc();
    nreset = 1'b1;
    cyc();

    // Single beat, AOI then AO, literal expectations.
    chk("model_pin_aoi", {28'b0, model(12'hFF3, 4'h0, 1'b1)}, 32'hC);
    chk("model_pin_ao", {28'b0, model(12'hFF3, 4'h0, 1'b0)}, 32'h3);
    chk("model_pin_or", {28'b0, model(12'h0F0, 4'h5, 1'b0)}, 32'h5);
    for (int t = 0; t < 2; t++) begin
      a = 12'hFF3; b = 4'h0; inv = (t == 0); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("lat_not_yet", {31'b0, out_valid}, 0);
      cyc();
      chk("lat_valid", {31'b0, out_valid}, 1);
      chk("lat_z", {28'b0, z}, (t == 0) ? 32'hC : 32'h3);
      cyc();
      chk("lat_one_cycle", {31'b0, out_valid}, 0);
    end
    drain();

    // 16 back-to-back beats at full throughput.
    for (int i = 0; i < 16; i++) begin
      a = N*DW'($urandom); b = M*DW'($urandom); inv = 1'($urandom); in_valid = 1'b1;
      chk("b2b_in_ready", {31'b0, in_ready}, 1);
      cyc();
    end
    drain();

    // Fill and stall, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = N*DW'($urandom); b = M*DW'($urandom); inv = 1'($urandom); in_valid = 1'b1;
      cyc();
    end
    chk("stall_in_ready", {31'b0, in_ready}, 0);
    chk("stall_out_valid", {31'b0, out_valid}, 1);
    held = z;
    cyc();
    cyc();
    chk("stall_z_stable", {28'b0, z}, {28'b0, held});
    drain();

    // Random valid/ready traffic.
    sent = 0;
    for (int i = 0; i < 600; i++) begin
      a = N*DW'($urandom); b = M*DW'($urandom); inv = 1'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      cyc();
      sent++;
    end
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = N*DW'($urandom); b = M*DW'($urandom); inv = 1'b1; in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_in_ready", {31'b0, in_ready}, 1);
    chk("midrst_z", {28'b0, z}, 0);
    cyc();
    nreset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = N*DW'($urandom); b = M*DW'($urandom); inv = 1'($urandom); in_valid = 1'b1;
      cyc();
    end
    drain();

    // Idle data toggling after a drain.
    for (int k = 0; k < 4; k++) begin
      a = N*DW'($urandom); b = M*DW'($urandom); inv = 1'($urandom); in_valid = 1'b0;
      cyc();
      cyc();
`ifdef OH_AOI_PIPE_HOLD_EN
      chk("idle_z_hold", {28'b0, z}, {28'b0, last_val});
`else
      chk("idle_z_track", {28'b0, z}, {28'b0, model(a, b, inv)});
`endif
      chk("idle_out_valid", {31'b0, out_valid}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
